// File: rtl/regfile_sb.sv
// regfile_sb -- register file with per-register busy scoreboard.
//
// Two combinational read ports, one synchronous write port, and a busy bit
// per register that tracks in-flight destinations so decode can stall on
// RAW/WAW hazards. Register 0 reads as zero and is never busy.
//
// Parameters:
//   WIDTH       data bits per register
//   IDX_W       index width, depth = 2**IDX_W
//   INIT_COUNT  registers 1..INIT_COUNT-1 reset to their own index, others 0
//
// Ports:
//   CLK, RST            clock (rising edge), async active-high reset
//   indexA/B, regA/B    read addresses and read data
//   busyA/B             busy bit of the addressed register
//   regWrite, writeIndex, writeData   writeback port (clears busy)
//   issueValid, issueIndex, issueReady  destination reservation handshake
//   flush               clears every reservation
//   busyCount           number of busy registers
//
// Build option:
//   REGFILE_BYPASS_EN   forward same-cycle writeback data to the read ports
//                       (busy output reads 0 for a forwarded index)

module regfile_sb #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned IDX_W      = 5,
  parameter int unsigned INIT_COUNT = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [IDX_W-1:0] indexA,
  input  logic [IDX_W-1:0] indexB,
  output logic [WIDTH-1:0] regA,
  output logic [WIDTH-1:0] regB,
  output logic             busyA,
  output logic             busyB,
  input  logic             regWrite,
  input  logic [IDX_W-1:0] writeIndex,
  input  logic [WIDTH-1:0] writeData,
  input  logic             issueValid,
  input  logic [IDX_W-1:0] issueIndex,
  output logic             issueReady,
  input  logic             flush,
  output logic [IDX_W:0]   busyCount
);

  localparam int unsigned    DEPTH   = 1 << IDX_W;
  localparam logic [IDX_W:0] CNT_MAX = {1'b0, {IDX_W{1'b1}}};

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [IDX_W:0]   cnt_q, cnt_d;

  logic wr_en;
  logic inc;
  logic dec;

  assign wr_en = regWrite && (writeIndex != '0);

  // Readiness looks only at the registered busy vector, so a writeback to a
  // busy register in the same cycle does not make it issuable yet.
  assign issueReady = issueValid && !flush &&
                      ((issueIndex == '0) || !busy_q[issueIndex]);

  assign inc = issueReady && (issueIndex != '0);
  assign dec = wr_en && busy_q[writeIndex] && !flush;

  // Writeback clears first, then an accepted issue sets. The only overlap is
  // an issue to a non-busy index that is also being written: the new
  // reservation wins, matching the +1 the counter takes in that case.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) busy_d[writeIndex] = 1'b0;
    if (inc)   busy_d[issueIndex] = 1'b1;
    if (flush) busy_d = '0;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (inc && !dec) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc) begin
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= (i >= 1 && i < INIT_COUNT) ? WIDTH'(i) : '0;
      end
    end else if (wr_en) begin
      regs_q[writeIndex] <= writeData;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busyCount = cnt_q;

`ifdef REGFILE_BYPASS_EN
  logic fwdA;
  logic fwdB;
  assign fwdA  = wr_en && (indexA == writeIndex);
  assign fwdB  = wr_en && (indexB == writeIndex);
  assign regA  = fwdA ? writeData : regs_q[indexA];
  assign regB  = fwdB ? writeData : regs_q[indexB];
  assign busyA = fwdA ? 1'b0 : busy_q[indexA];
  assign busyB = fwdB ? 1'b0 : busy_q[indexB];
`else
  assign regA  = regs_q[indexA];
  assign regB  = regs_q[indexB];
  assign busyA = busy_q[indexA];
  assign busyB = busy_q[indexB];
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb -- directed self-checking bench for regfile_sb (defaults:
// WIDTH=32, IDX_W=5, INIT_COUNT=16). Honours REGFILE_BYPASS_EN.

module tb_regfile_sb;

  logic        CLK = 1'b0;
  logic        RST;
  logic [4:0]  indexA, indexB;
  logic [31:0] regA, regB;
  logic        busyA, busyB;
  logic        regWrite;
  logic [4:0]  writeIndex;
  logic [31:0] writeData;
  logic        issueValid;
  logic [4:0]  issueIndex;
  logic        issueReady;
  logic        flush;
  logic [5:0]  busyCount;

  int npass = 0;
  int ntotal = 0;

  regfile_sb #(.WIDTH(32), .IDX_W(5), .INIT_COUNT(16)) dut (
    .CLK(CLK), .RST(RST),
    .indexA(indexA), .indexB(indexB),
    .regA(regA), .regB(regB),
    .busyA(busyA), .busyB(busyB),
    .regWrite(regWrite), .writeIndex(writeIndex), .writeData(writeData),
    .issueValid(issueValid), .issueIndex(issueIndex), .issueReady(issueReady),
    .flush(flush), .busyCount(busyCount)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntotal++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    regWrite = 0; writeIndex = 0; writeData = 0;
    issueValid = 0; issueIndex = 0; flush = 0;
  endtask

  task automatic do_issue(input logic [4:0] idx);
    issueValid = 1; issueIndex = idx;
    tick();
    idle();
  endtask

  initial begin
    RST = 1; indexA = 0; indexB = 7;
    idle();
    #1;
    // reset contents
    check("rst_r0", regA, 32'd0);
    check("rst_r7", regB, 32'd7);
    indexA = 15; indexB = 16; #1;
    check("rst_r15", regA, 32'd15);
    check("rst_r16", regB, 32'd0);
    indexA = 31; #1;
    check("rst_r31", regA, 32'd0);
    check("rst_busyA", {31'd0, busyA}, 32'd0);
    check("rst_cnt", {26'd0, busyCount}, 32'd0);
    issueValid = 1; issueIndex = 3; #1;
    check("rst_ready", {31'd0, issueReady}, 32'd1);
    idle();
    @(negedge CLK); RST = 0;
    tick();

    // issue 3, then refuse a second issue to 3
    issueValid = 1; issueIndex = 3; #1;
    check("iss3_ready", {31'd0, issueReady}, 32'd1);
    tick(); idle();
    indexA = 3; #1;
    check("iss3_busy", {31'd0, busyA}, 32'd1);
    check("iss3_cnt", {26'd0, busyCount}, 32'd1);
    issueValid = 1; issueIndex = 3; #1;
    check("iss3_again", {31'd0, issueReady}, 32'd0);
    tick(); idle(); #1;
    check("iss3_cnt_hold", {26'd0, busyCount}, 32'd1);

    // writeback 3
    regWrite = 1; writeIndex = 3; writeData = 32'hDEADBEEF; #1;
`ifdef REGFILE_BYPASS_EN
    check("wb3_same", regA, 32'hDEADBEEF);
    check("wb3_same_busy", {31'd0, busyA}, 32'd0);
`else
    check("wb3_same", regA, 32'd3);
    check("wb3_same_busy", {31'd0, busyA}, 32'd1);
`endif
    tick(); idle(); #1;
    check("wb3_data", regA, 32'hDEADBEEF);
    check("wb3_busy", {31'd0, busyA}, 32'd0);
    check("wb3_cnt", {26'd0, busyCount}, 32'd0);

    // register 0
    regWrite = 1; writeIndex = 0; writeData = 32'h12345678;
    tick(); idle();
    indexA = 0; #1;
    check("r0_read", regA, 32'd0);
    issueValid = 1; issueIndex = 0; #1;
    check("r0_ready", {31'd0, issueReady}, 32'd1);
    tick(); idle(); #1;
    check("r0_cnt", {26'd0, busyCount}, 32'd0);
    check("r0_busy", {31'd0, busyA}, 32'd0);

    // writeback + issue to the same busy register
    do_issue(5'd4);
    regWrite = 1; writeIndex = 4; writeData = 32'h44;
    issueValid = 1; issueIndex = 4; #1;
    check("same_ready", {31'd0, issueReady}, 32'd0);
    tick(); idle();
    indexA = 4; #1;
    check("same_busy", {31'd0, busyA}, 32'd0);
    check("same_cnt", {26'd0, busyCount}, 32'd0);
    check("same_data", regA, 32'h44);

    // writeback 4 + issue 9
    do_issue(5'd4);
    regWrite = 1; writeIndex = 4; writeData = 32'h45;
    issueValid = 1; issueIndex = 9; #1;
    check("diff_ready", {31'd0, issueReady}, 32'd1);
    tick(); idle();
    indexB = 9; #1;
    check("diff_cnt", {26'd0, busyCount}, 32'd1);
    check("diff_busy9", {31'd0, busyB}, 32'd1);
    check("diff_busy4", {31'd0, busyA}, 32'd0);
    regWrite = 1; writeIndex = 9; writeData = 32'h99;
    tick(); idle(); #1;
    check("diff_clean", {26'd0, busyCount}, 32'd0);

    // flush with same-cycle writeback and issue
    do_issue(5'd1); do_issue(5'd2); do_issue(5'd3);
    check("fl_cnt3", {26'd0, busyCount}, 32'd3);
    flush = 1; regWrite = 1; writeIndex = 2; writeData = 32'hAA;
    issueValid = 1; issueIndex = 5; #1;
    check("fl_ready", {31'd0, issueReady}, 32'd0);
    tick(); idle();
    indexA = 2; indexB = 5; #1;
    check("fl_cnt0", {26'd0, busyCount}, 32'd0);
    check("fl_data", regA, 32'hAA);
    check("fl_busy2", {31'd0, busyA}, 32'd0);
    check("fl_busy5", {31'd0, busyB}, 32'd0);

    // async reset between edges
    do_issue(5'd7);
    indexB = 3; #2;
    RST = 1; #1;
    check("ar_r2", regA, 32'd2);
    check("ar_r3", regB, 32'd3);
    check("ar_cnt", {26'd0, busyCount}, 32'd0);
    RST = 0;
    tick();

    // bypass of a busy register
    do_issue(5'd6);
    indexA = 6;
    regWrite = 1; writeIndex = 6; writeData = 32'h55; #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_data", regA, 32'h55);
    check("byp_busy", {31'd0, busyA}, 32'd0);
`else
    check("byp_data", regA, 32'd6);
    check("byp_busy", {31'd0, busyA}, 32'd1);
`endif
    tick(); idle(); #1;
    check("byp_after", regA, 32'h55);
    check("byp_after_busy", {31'd0, busyA}, 32'd0);

    // fill every register: counter tops out at 31
    for (int i = 1; i < 32; i++) do_issue(5'(i));
    check("full_cnt", {26'd0, busyCount}, 32'd31);
    issueValid = 1; issueIndex = 31; #1;
    check("full_ready", {31'd0, issueReady}, 32'd0);
    tick(); idle(); #1;
    check("full_hold", {26'd0, busyCount}, 32'd31);
    regWrite = 1; writeIndex = 31; writeData = 32'h1F;
    tick(); idle(); #1;
    check("full_dec", {26'd0, busyCount}, 32'd30);
    flush = 1;
    tick(); idle(); #1;
    check("full_flush", {26'd0, busyCount}, 32'd0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
